// File: rtl/perip_rmw_ctrl.sv
// Load/store sequencer for the single perip_* bus: sized loads with lane
// extraction and sign/zero extension, byte/half stores as read-modify-write.
module perip_rmw_ctrl #(
    parameter int RD_LATENCY = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] perip_addr,
    output logic        perip_wen,
    output logic [1:0]  perip_mask,
    output logic [31:0] perip_wdata,
    input  logic [31:0] perip_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; the requester holds its fields until then.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  lat_cnt;
    logic [2:0]  op_q;
    logic        wen_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        req_err;

    assign req_ready = (state == S_IDLE) && !cpu_rst;
    assign accept    = req_valid && req_ready;

    function automatic logic [1:0] size_code(input logic [2:0] op);
        case (op[1:0])
            2'b00:   size_code = 2'b00;
            2'b01:   size_code = 2'b01;
            default: size_code = 2'b11;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'd0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] w, input logic [15:0] d);
        logic [31:0] m;
        m = w;
        if (op == 3'b000)
            m[{lane, 3'b000} +: 8] = d[7:0];
        else if (lane[1])
            m[31:16] = d;
        else
            m[15:0] = d;
        merge = m;
    endfunction

    always_comb begin
        req_err = 1'b0;
        case (req_op)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = (req_addr[1:0] != 2'b00);
            3'b100:  req_err = req_wen;
            3'b101:  req_err = req_wen || req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state       <= S_IDLE;
            lat_cnt     <= 2'd0;
            op_q        <= 3'd0;
            wen_q       <= 1'b0;
            lane_q      <= 2'd0;
            wdata_q     <= 16'd0;
            perip_addr  <= 32'd0;
            perip_wen   <= 1'b0;
            perip_mask  <= 2'b11;
            perip_wdata <= 32'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        wen_q   <= req_wen;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (req_wen && req_op == 3'b010) begin
                            state       <= S_WRITE;
                            perip_addr  <= req_addr;
                            perip_wen   <= 1'b1;
                            perip_mask  <= 2'b11;
                            perip_wdata <= req_wdata;
                        end else begin
                            // Sub-word stores read the whole word before merging.
                            state      <= S_READ;
                            lat_cnt    <= 2'd0;
                            perip_addr <= req_addr;
                            perip_mask <= req_wen ? 2'b11 : size_code(req_op);
                        end
                    end
                end
                S_READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (wen_q) begin
                            state       <= S_WRITE;
                            perip_wen   <= 1'b1;
                            perip_mask  <= size_code(op_q);
                            perip_wdata <= merge(op_q, lane_q, perip_rdata, wdata_q);
                        end else begin
                            state      <= S_RESP;
                            perip_mask <= 2'b11;
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b0;
                            rsp_rdata  <= load_ext(op_q, lane_q, perip_rdata);
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    state      <= S_RESP;
                    perip_wen  <= 1'b0;
                    perip_mask <= 2'b11;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                    rsp_rdata  <= 32'd0;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/perip_rmw_ctrl.md
Name: perip_rmw_ctrl

Overview:
- Sequences data-memory/peripheral accesses on the single perip_* bus port for the CPU load/store path.
- Accepts one load or store request at a time through a valid/ready handshake. Waits out the bus read latency, then returns a sign- or zero-extended load result.
- SB/SH stores run as read-modify-write: read the full word, merge the byte or half, write the word back. Misaligned and unsupported requests are flagged without touching the bus.

Parameters:
- RD_LATENCY, 1, cycles perip_rdata needs after perip_addr is presented; legal range 1..4.

Ports:
- cpu_clk  in  1  clock, all state on the rising edge
- cpu_rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned or unsupported op
- perip_addr  out  32  bus address (the full byte address, not word-aligned)
- perip_wen  out  1  bus write strobe
- perip_mask  out  2  size code: 00 byte, 01 half, 11 word
- perip_wdata  out  32  full 32-bit word to write
- perip_rdata  in  32  raw bus read word

Behaviour:
- Reset (synchronous, active-high), applied at the next edge:
  - state=IDLE, latency counter=0.
  - perip_addr=0, perip_wen=0, perip_mask=11, perip_wdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while cpu_rst=1.
- Reset mid-operation aborts the access: no write issued, no response. A perip_wen already high drops at the reset edge.
- req_ready = (state==IDLE) && !cpu_rst, combinational. Accept = req_valid && req_ready at an edge. The request is latched at acceptance; later input changes are ignored.
- States: IDLE, READ, WRITE, RESP. Accept at edge k. All bus outputs are registered.
- Error path (IDLE -> RESP, rsp_valid in cycle k+1, rsp_err=1, no bus activity). A request is an error if:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - op 011, 110 or 111;
  - store with BU/HU.
- Load path (IDLE -> READ -> RESP):
  - READ lasts RD_LATENCY cycles, with perip_addr=req_addr, perip_wen=0, perip_mask=size code.
  - perip_rdata is sampled on the last READ edge. The selected lane is chosen by addr[1:0] (byte) or addr[1] (half), then extended: B/H sign, BU/HU zero.
  - rsp_valid in cycle k+1+RD_LATENCY.
- SW path (IDLE -> WRITE -> RESP):
  - WRITE is one cycle: perip_wen=1, perip_mask=11, perip_wdata=req_wdata.
  - rsp_valid at k+2.
- SB/SH path (IDLE -> READ -> WRITE -> RESP):
  - READ uses perip_mask=11.
  - The sampled word is merged with req_wdata[7:0] at lane addr[1:0], or req_wdata[15:0] at lane addr[1]; all other bytes are preserved.
  - WRITE: perip_wen=1, perip_mask=00/01, perip_wdata=merged word.
  - rsp_valid at k+2+RD_LATENCY.
- RESP lasts one cycle, then returns to IDLE. req_ready=1 again in the cycle after RESP. Back-to-back loads give one response every RD_LATENCY+2 cycles.
- perip_wen is high only in WRITE, exactly one cycle per store. It is never high for loads or errors.
- Outside READ/WRITE the bus is idle: perip_wen=0, perip_mask=11. perip_addr and perip_wdata hold their last value.
- rsp_rdata and rsp_err hold until the next RESP. rsp_valid is 0 outside RESP.
- Latency counter: counts 0..RD_LATENCY-1 and resets to 0 when READ is entered. With RD_LATENCY=1, READ is a single cycle.

Test Plan:
- Reset, RD_LATENCY=1. Load LB addr 0x103 with memory word 0x80FF_7F01 -> rsp_valid at k+2, rsp_rdata=0xFFFF_FF80; LBU same addr -> 0x0000_0080; LH addr 0x102 -> 0xFFFF_80FF.
- SW addr 0x200, data 0xDEAD_BEEF -> perip_wen high exactly in cycle k+1 with mask 11, wdata 0xDEAD_BEEF; rsp_valid at k+2, rsp_err=0.
- Memory 0x1122_3344 at 0x300. SB 0x301 data 0xAB -> WRITE wdata 0x1122_AB44, mask 00. Then SH 0x302 data 0xCDEF -> 0xCDEF_AB44, mask 01; rsp at k+3 each.
- Misaligned LW 0x402, SH 0x401, op 011 -> rsp_valid at k+1, rsp_err=1, rsp_rdata=0, perip_wen never asserted; req_ready returns next cycle.
- RD_LATENCY=3: LW 0x500 (memory 0x0BAD_F00D) -> READ 3 cycles, rsp at k+4, data 0x0BAD_F00D; SB -> write at k+4, rsp at k+5; req_valid held high shows no accept before IDLE.
- Assert cpu_rst during READ of an SB -> no perip_wen, no rsp_valid; outputs at reset values next cycle; new LW after deassert completes normally.
